// File: rtl/rgb_sram_packer.sv
// Packs pairs of 8-bit RGB pixels into three 16-bit words and streams
// them through a small FIFO into the RGB region of external SRAM.
module rgb_sram_packer #(
    parameter logic [17:0] BASE_ADDR  = 18'd146944,
    parameter int          NUM_PIXELS = 76800,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Pixel_valid,
    output logic        Pixel_ready,
    input  logic [7:0]  R_in,
    input  logic [7:0]  G_in,
    input  logic [7:0]  B_in,
    input  logic        SRAM_grant,
    output logic        Write_req,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    output logic        Busy,
    output logic        Done
);

    localparam int NUM_WORDS = NUM_PIXELS * 3 / 2;
    localparam int PC_W      = $clog2(NUM_PIXELS + 1);
    localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pixel_count_q, pixel_count_d;
    logic [17:0]       word_count_q, word_count_d;
    logic              phase_q, phase_d;
    logic [7:0]        b_held_q, b_held_d;
    logic [15:0]       mem_q [FIFO_DEPTH];
    logic [15:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  push_n;
    logic              we_n_q, we_n_d;
    logic [17:0]       addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              xfer, pop;

    function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A pair of pixels needs room for two words in the worst case
    assign Pixel_ready     = (state_q == RUN) &&
                             (count_q <= CNT_W'(FIFO_DEPTH - 2));
    assign Write_req       = (state_q != IDLE) && (count_q != '0);
    assign xfer            = Pixel_valid && Pixel_ready;
    assign pop             = SRAM_grant && Write_req;
    assign SRAM_address    = addr_q;
    assign SRAM_write_data = wdata_q;
    assign SRAM_we_n       = we_n_q;
    assign Busy            = busy_q;
    assign Done            = done_q;

    // Next state: packing, FIFO push/pop, SRAM write and frame control
    always_comb begin
        state_d       = state_q;
        pixel_count_d = pixel_count_q;
        word_count_d  = word_count_q;
        phase_d       = phase_q;
        b_held_d      = b_held_q;
        mem_d         = mem_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        push_n        = '0;
        we_n_d        = 1'b1;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        done_d        = 1'b0;
        if (Start) begin
            // Restart discards everything in flight, including this cycle
            state_d       = RUN;
            pixel_count_d = '0;
            word_count_d  = '0;
            phase_d       = 1'b0;
            rd_ptr_d      = '0;
            wr_ptr_d      = '0;
            count_d       = '0;
        end else begin
            if (xfer) begin
                pixel_count_d = pixel_count_q + PC_W'(1);
                if (!phase_q) begin
                    mem_d[wr_ptr_q] = {R_in, G_in};
                    b_held_d        = B_in;
                    push_n          = CNT_W'(1);
                    wr_ptr_d        = inc(wr_ptr_q);
                    phase_d         = 1'b1;
                end else begin
                    mem_d[wr_ptr_q]      = {b_held_q, R_in};
                    mem_d[inc(wr_ptr_q)] = {G_in, B_in};
                    push_n               = CNT_W'(2);
                    wr_ptr_d             = inc(inc(wr_ptr_q));
                    phase_d              = 1'b0;
                end
            end
            if (pop) begin
                we_n_d       = 1'b0;
                addr_d       = BASE_ADDR + word_count_q;
                wdata_d      = mem_q[rd_ptr_q];
                rd_ptr_d     = inc(rd_ptr_q);
                word_count_d = word_count_q + 18'd1;
            end
            count_d = count_q + push_n - CNT_W'(pop);
            unique case (state_q)
                RUN: begin
                    if (pixel_count_d == PC_W'(NUM_PIXELS)) state_d = FLUSH;
                end
                FLUSH: begin
                    if (pop && word_count_q == 18'(NUM_WORDS - 1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    // State registers with synchronous reset
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q       <= IDLE;
            pixel_count_q <= '0;
            word_count_q  <= '0;
            phase_q       <= 1'b0;
            b_held_q      <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            we_n_q        <= 1'b1;
            addr_q        <= '0;
            wdata_q       <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pixel_count_q <= pixel_count_d;
            word_count_q  <= word_count_d;
            phase_q       <= phase_d;
            b_held_q      <= b_held_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            we_n_q        <= we_n_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    // FIFO storage needs no reset; occupancy tracks validity
    always_ff @(posedge Clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_rgb_sram_packer.sv
// Directed bench for rgb_sram_packer on a reduced 12-pixel frame.
// Checks packing, addressing, stalls, restart and reset.
module tb_rgb_sram_packer;

    localparam int          NP   = 12;
    localparam int          NW   = NP * 3 / 2;
    localparam logic [17:0] BASE = 18'd146944;

    typedef struct {
        logic [7:0]  r0, g0, b0, r1, g1, b1;
        logic [15:0] w0, w1, w2;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, start, pv, pr, grant, wreq, we_n, busy, done;
    logic [7:0]  r, g, b;
    logic [17:0] addr;
    logic [15:0] wdata;

    int          nvec = 0;
    int          nfail = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          acc0 = 0;
    logic [17:0] wa[$];
    logic [15:0] wd[$];
    int          wc[$];
    vec_t        vt [6];

    rgb_sram_packer #(
        .BASE_ADDR (BASE),
        .NUM_PIXELS(NP),
        .FIFO_DEPTH(4)
    ) dut (
        .Clock          (clk),
        .Reset          (rst),
        .Start          (start),
        .Pixel_valid    (pv),
        .Pixel_ready    (pr),
        .R_in           (r),
        .G_in           (g),
        .B_in           (b),
        .SRAM_grant     (grant),
        .Write_req      (wreq),
        .SRAM_address   (addr),
        .SRAM_write_data(wdata),
        .SRAM_we_n      (we_n),
        .Busy           (busy),
        .Done           (done)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every SRAM write and Done pulse, sampled mid-cycle
    always @(negedge clk) begin
        if (we_n === 1'b0) begin
            wa.push_back(addr);
            wd.push_back(wdata);
            wc.push_back(cyc);
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic bound_fail(input string nm);
        nvec++;
        nfail++;
        $display("FAIL %s: timed out", nm);
    endtask

    function automatic logic [23:0] pix(input int i);
        vec_t v;
        v = vt[i / 2];
        return (i % 2 == 0) ? {v.r0, v.g0, v.b0} : {v.r1, v.g1, v.b1};
    endfunction

    function automatic logic [15:0] exp_word(input int i);
        vec_t v;
        v = vt[i / 3];
        case (i % 3)
            0:       return v.w0;
            1:       return v.w1;
            default: return v.w2;
        endcase
    endfunction

    function automatic logic pick_grant(input int gm);
        if (gm == 2) return 1'($urandom_range(0, 1));
        return (gm == 1);
    endfunction

    task automatic do_start();
        start = 1'b1;
        pv    = 1'b0;
        grant = 1'b0;
        step();
        start = 1'b0;
        wa.delete();
        wd.delete();
        wc.delete();
        done_cnt = 0;
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic send(input int i, input int gm);
        logic rdy;
        bit   ok;
        {r, g, b} = pix(i);
        pv = 1'b1;
        ok = 0;
        for (int k = 0; k < 200 && !ok; k++) begin
            grant = pick_grant(gm);
            rdy   = pr;
            step();
            if (rdy) ok = 1;
        end
        if (!ok) bound_fail($sformatf("accept_pixel_%0d", i));
        if (i == 0) acc0 = cyc;
    endtask

    task automatic feed(input int from, input bit rv, input int gm);
        for (int i = from; i < NP; i++) begin
            if (rv) begin
                repeat ($urandom_range(0, 2)) begin
                    pv    = 1'b0;
                    grant = pick_grant(gm);
                    step();
                end
            end
            send(i, gm);
        end
        pv = 1'b0;
    endtask

    task automatic finish_frame(input string tag, input int gm);
        bit seen;
        seen = 0;
        pv   = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            grant = (gm == 0) ? 1'b1 : pick_grant(gm);
            step();
            if (done) seen = 1;
        end
        if (!seen) bound_fail({tag, "_done"});
        chk({tag, "_busy_low"}, 32'(busy), 32'd0);
        grant = 1'b1;
        repeat (3) step();
        chk({tag, "_done_once"}, 32'(done_cnt), 32'd1);
        chk({tag, "_nwrites"}, 32'(wa.size()), 32'(NW));
        for (int i = 0; i < NW; i++) begin
            if (i < wa.size()) begin
                chk($sformatf("%s_addr%0d", tag, i), 32'(wa[i]),
                    32'(BASE + 18'(i)));
                chk($sformatf("%s_data%0d", tag, i), 32'(wd[i]),
                    32'(exp_word(i)));
            end
        end
    endtask

    initial begin
        int acc;
        vt[0] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                  16'h1122, 16'h3344, 16'h5566};
        vt[1] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6,
                  16'hA1B2, 16'hC3D4, 16'hE5F6};
        vt[2] = '{8'h00, 8'hFF, 8'h01, 8'hFE, 8'h02, 8'hFD,
                  16'h00FF, 16'h01FE, 16'h02FD};
        vt[3] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC,
                  16'h1234, 16'h5678, 16'h9ABC};
        vt[4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hCA, 8'hFE,
                  16'hDEAD, 16'hBEEF, 16'hCAFE};
        vt[5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                  16'h0102, 16'h0304, 16'h0506};

        rst   = 1'b1;
        start = 1'b0;
        pv    = 1'b0;
        grant = 1'b0;
        {r, g, b} = '0;
        repeat (2) step();
        chk("rst_ready", 32'(pr), 32'd0);
        chk("rst_wreq", 32'(wreq), 32'd0);
        chk("rst_we_n", 32'(we_n), 32'd1);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_data", 32'(wdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        step();

        // Continuous pixels, grant always high
        do_start();
        chk("start_ready", 32'(pr), 32'd1);
        feed(0, 0, 1);
        finish_frame("cont", 1);
        if (wc.size() >= 3) begin
            chk("latency", 32'(wc[0]), 32'(acc0 + 1));
            chk("b2b_1", 32'(wc[1]), 32'(wc[0] + 1));
            chk("b2b_2", 32'(wc[2]), 32'(wc[1] + 1));
        end else begin
            bound_fail("b2b_writes");
        end

        // Random valid and grant
        do_start();
        feed(0, 1, 2);
        finish_frame("rand", 2);

        // Grant held low: FIFO fills, upstream stalls
        do_start();
        acc = 0;
        grant = 1'b0;
        for (int k = 0; k < 20; k++) begin
            logic rdy;
            {r, g, b} = pix(acc);
            pv  = 1'b1;
            rdy = pr;
            step();
            if (rdy) acc++;
        end
        chk("stall_accepted", 32'(acc), 32'd2);
        chk("stall_ready", 32'(pr), 32'd0);
        chk("stall_wreq", 32'(wreq), 32'd1);
        chk("stall_nowrite", 32'(wa.size()), 32'd0);
        feed(2, 0, 1);
        finish_frame("stall", 1);

        // Odd-pixel push of two words together with a pop
        do_start();
        send(0, 0);
        send(1, 1);
        pv = 1'b0;
        chk("pp_we0", 32'(we_n), 32'd0);
        chk("pp_d0", 32'(wdata), 32'h1122);
        grant = 1'b1;
        step();
        chk("pp_d1", 32'(wdata), 32'h3344);
        step();
        chk("pp_d2", 32'(wdata), 32'h5566);
        chk("pp_a2", 32'(addr), 32'(BASE + 18'd2));
        step();
        chk("pp_we_idle", 32'(we_n), 32'd1);
        chk("pp_empty", 32'(wreq), 32'd0);

        // Restart mid-frame with data still queued
        send(2, 0);
        send(3, 0);
        pv = 1'b0;
        chk("pre_restart_wreq", 32'(wreq), 32'd1);
        do_start();
        chk("restart_wreq", 32'(wreq), 32'd0);
        feed(0, 0, 1);
        finish_frame("restart", 1);

        // Reset in the middle of a frame
        do_start();
        for (int i = 0; i < 5; i++) send(i, 1);
        rst   = 1'b1;
        pv    = 1'b1;
        grant = 1'b1;
        step();
        chk("mrst_ready", 32'(pr), 32'd0);
        chk("mrst_wreq", 32'(wreq), 32'd0);
        chk("mrst_we_n", 32'(we_n), 32'd1);
        chk("mrst_addr", 32'(addr), 32'd0);
        chk("mrst_data", 32'(wdata), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        rst = 1'b0;
        pv  = 1'b0;
        step();
        do_start();
        feed(0, 0, 1);
        finish_frame("after_rst", 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
